// File: rtl/fifo_burst_reader_pkg.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader_pkg
// Shared types and parameter checks for the FIFO burst reader.
//   rd_state_t    : drain FSM states (IDLE / BURST / FLUSH)
//   burst_len_ok  : constant function for the BURST_LEN >= 2 check
// ---------------------------------------------------------------------------
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

  localparam int MIN_BURST_LEN = 2;

  // A one-beat "burst" would make every beat both first and last, which
  // breaks the almost-empty based start condition, so two is the floor.
  function automatic bit burst_len_ok(input int burst_len);
    return burst_len >= MIN_BURST_LEN;
  endfunction

endpackage

// File: rtl/fifo_rd_outreg.sv
// ---------------------------------------------------------------------------
// fifo_rd_outreg
// Single-entry valid/ready output register holding {last, data}.
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture load_data/load_last and raise m_valid
//   load_data   : WIDTH-bit payload to capture
//   load_last   : last-beat flag to capture
//   m_ready     : downstream ready
//   m_data      : registered payload
//   m_valid     : registered valid
//   m_last      : registered last flag
//   slot_free   : register may be (re)loaded this cycle
// ---------------------------------------------------------------------------
module fifo_rd_outreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             slot_free
);

  logic [WIDTH:0] payload_reg;
  logic           valid_reg;

  // A load while the current beat is being accepted replaces it in place,
  // so back-to-back beats flow without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (load) begin
      payload_reg <= {load_last, load_data};
      valid_reg   <= 1'b1;
    end else if (valid_reg && m_ready) begin
      valid_reg   <= 1'b0;
    end
  end

  assign slot_free = !valid_reg || m_ready;
  assign m_data    = payload_reg[WIDTH-1:0];
  assign m_last    = payload_reg[WIDTH];
  assign m_valid   = valid_reg;

endmodule

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
// Drains a sync_fifo (pop/dout/empty/a_empty) into a registered valid/ready
// stream grouped into BURST_LEN-beat bursts, with m_last on the final beat.
// Optional feature macro: FIFO_BURST_READER_TIMEOUT_EN -- when defined, a
// residue of fewer than BURST_LEN entries that sits idle for TIMEOUT cycles
// is flushed one entry at a time as single-beat bursts.
//   clk, rst     : clock, synchronous active-high reset
//   fifo_dout    : FIFO head data (valid while !fifo_empty)
//   fifo_empty   : FIFO empty flag
//   fifo_a_empty : FIFO almost-empty flag (FIFO built with AE_LEVEL=BURST_LEN-1)
//   fifo_pop     : combinational pop strobe to the FIFO
//   m_data       : stream data (registered)
//   m_valid      : stream valid (registered)
//   m_last       : last beat of burst (registered)
//   m_ready      : consumer ready
//   busy         : FSM not idle or a beat is pending
//   burst_done   : pulses when the m_last beat is accepted
// ---------------------------------------------------------------------------
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = $clog2(BURST_LEN),
  parameter int TMR_W     = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_a_empty,
  output logic             fifo_pop,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             burst_done
);

  generate
    if (!burst_len_ok(BURST_LEN) || TIMEOUT < 1 || TMR_W < 1) begin : g_param_check
      $error("fifo_burst_reader: BURST_LEN must be >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  rd_state_t        state_reg, state_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic             slot_free;
  logic             load_last;

  fifo_rd_outreg #(
    .WIDTH (WIDTH)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (fifo_pop),
    .load_data (fifo_dout),
    .load_last (load_last),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .slot_free (slot_free)
  );

  // Popping only when the FIFO is non-empty doubles as the empty guard:
  // with no pop, neither the state nor the beat counter advances.
  assign fifo_pop   = slot_free && !fifo_empty &&
                      (state_reg == BURST || state_reg == FLUSH);
  assign busy       = (state_reg != IDLE) || m_valid;
  assign burst_done = m_valid && m_ready && m_last;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_reg, tmr_next;
`endif

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    load_last     = 1'b0;
    case (state_reg)
      IDLE: begin
        // a_empty low means at least BURST_LEN entries are present, so a
        // started burst can always complete without waiting on the writer.
        if (!fifo_a_empty) begin
          state_next    = BURST;
          beat_cnt_next = '0;
        end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        else if (!fifo_empty && tmr_reg == TMR_MAX) begin
          state_next = FLUSH;
        end
`endif
      end
      BURST: begin
        load_last = (beat_cnt_reg == LAST_BEAT);
        if (fifo_pop) begin
          // Counter parks at LAST_BEAT; it is cleared on the next burst start.
          if (load_last) state_next    = IDLE;
          else           beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
      end
      FLUSH: begin
        load_last = 1'b1;
        if (fifo_pop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  // Counts idle cycles spent holding a partial residue; any state change or
  // a full/empty FIFO restarts the count.
  always_comb begin
    tmr_next = '0;
    if (state_reg == IDLE && state_next == IDLE && !fifo_empty && fifo_a_empty) begin
      tmr_next = (tmr_reg == TMR_MAX) ? tmr_reg : tmr_reg + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tmr_reg <= '0;
    else     tmr_reg <= tmr_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
// Bench for fifo_burst_reader with a behavioural FIFO in front of it and a
// scoreboard of expected {data,last} beats derived from push order.
// FIFO_BURST_READER_TIMEOUT_EN selects the timeout scenario instead of the
// "partial residue stays put" scenario.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int WIDTH     = 32;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 16;
  localparam int DEPTH     = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_a_empty;
  logic             fifo_pop;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic             busy;
  logic             burst_done;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH     (WIDTH),
    .BURST_LEN (BURST_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_a_empty (fifo_a_empty),
    .fifo_pop     (fifo_pop),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .busy         (busy),
    .burst_done   (burst_done)
  );

  // ---------------- behavioural FIFO (AE_LEVEL = BURST_LEN-1) -------------
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  int               fill;
  logic             push_en     = 1'b0;
  logic [WIDTH-1:0] push_data   = '0;
  logic             flush_fifo  = 1'b0;
  logic             force_empty = 1'b0;

  assign fill         = wr_ptr - rd_ptr;
  assign fifo_empty   = force_empty || (fill == 0);
  assign fifo_a_empty = force_empty || (fill <= BURST_LEN - 1);
  assign fifo_dout    = mem[rd_ptr % DEPTH];

  always @(posedge clk) begin
    if (flush_fifo) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_en) begin
        mem[wr_ptr % DEPTH] <= push_data;
        wr_ptr <= wr_ptr + 1;
      end
      if (fifo_pop && fill > 0) rd_ptr <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard and checking -------------------------------
  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  beat_t exp_q[$];
  int    push_idx = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every BURST_LEN-th word pushed since reset closes a burst; a word that
  // will be flushed by the timeout is a burst of its own.
  task automatic push_word(input logic [WIDTH-1:0] d, input bit single);
    beat_t b;
    b.d = d;
    b.l = single ? 1'b1 : ((push_idx % BURST_LEN) == BURST_LEN - 1);
    if (!single) push_idx++;
    exp_q.push_back(b);
    push_en   = 1'b1;
    push_data = d;
    @(posedge clk); #1;
    push_en   = 1'b0;
  endtask

  // ---------------- m_ready driver ----------------------------------------
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom % 2);
        default: m_ready = 1'b1;
      endcase
    end
  end

  // ---------------- output monitor ----------------------------------------
  int               cyc = 0;
  int               acc_cnt = 0;
  int               done_cnt = 0;
  int               ae_fall_cyc = -1;
  int               ef_fall_cyc = -1;
  int               rise_q[$];
  logic             prev_ae = 1'b1;
  logic             prev_ef = 1'b1;
  logic             prev_valid = 1'b0;
  logic             stalled = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;
  logic             stall_last = 1'b0;

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (rst) begin
      stalled    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("no_pop_when_empty", fifo_pop & fifo_empty, 0);
      if (stalled) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, stall_data);
        check("stall_last", m_last, stall_last);
      end
      if (m_valid && m_ready) begin
        acc_cnt++;
        $display("beat %0d data=%08h last=%0b", acc_cnt, m_data, m_last);
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("data", m_data, b.d);
          check("last", m_last, b.l);
          check("burst_done", burst_done, b.l);
        end
      end else begin
        check("burst_done_quiet", burst_done, 0);
      end
      if (m_valid) check("busy_with_valid", busy, 1);
      if (burst_done) done_cnt++;
      if (prev_ae && !fifo_a_empty && ae_fall_cyc < 0) ae_fall_cyc = cyc;
      if (prev_ef && !fifo_empty && ef_fall_cyc < 0) ef_fall_cyc = cyc;
      if (m_valid && !prev_valid) rise_q.push_back(cyc);
      stalled    = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      prev_valid = m_valid;
    end
    prev_ae = fifo_a_empty;
    prev_ef = fifo_empty;
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
    check({"idle_", tag}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic mark_timing();
    ae_fall_cyc = -1;
    ef_fall_cyc = -1;
    rise_q.delete();
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int base_acc;
    int base_done;
    int n;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_pop", fifo_pop, 0);
    check("rst_burst_done", burst_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: two full bursts, always ready, start latency
    ready_mode = 0;
    mark_timing();
    base_done = done_cnt;
    for (int i = 0; i < 8; i++) push_word(32'hA0 + 32'(i), 1'b0);
    wait_drain("t1");
    check("t1_done_pulses", done_cnt - base_done, 2);
    check("t1_valid_seen", rise_q.size() != 0, 1);
    if (rise_q.size() != 0) check("t1_latency", rise_q[0] - ae_fall_cyc, 2);

    // 2: same data with ready toggling every cycle
    ready_mode = 1;
    base_acc   = acc_cnt;
    for (int i = 0; i < 8; i++) push_word(32'hA0 + 32'(i), 1'b0);
    wait_drain("t2");
    check("t2_beats", acc_cnt - base_acc, 8);
    ready_mode = 0;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // 3: partial residue flushed one entry per timeout period
    mark_timing();
    push_word(32'hB0, 1'b1);
    push_word(32'hB1, 1'b1);
    wait_drain("t3");
    check("t3_flush_count", rise_q.size(), 2);
    if (rise_q.size() >= 2) begin
      check("t3_first_delay", rise_q[0] - ef_fall_cyc, TIMEOUT + 1);
      check("t3_second_delay", rise_q[1] - rise_q[0], TIMEOUT + 1);
    end
`else
    // 4: partial residue stays until a full burst is available
    push_word(32'hB0, 1'b0);
    push_word(32'hB1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("t4_hold_valid", m_valid, 0);
    end
    @(posedge clk); #1;
    push_word(32'hB2, 1'b0);
    push_word(32'hB3, 1'b0);
    wait_drain("t4");
`endif

    // 5: reset after two beats of a burst
    base_acc = acc_cnt;
    for (int i = 0; i < 4; i++) push_word(32'hC0 + 32'(i), 1'b0);
    n = 0;
    while (acc_cnt < base_acc + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_two_beats", acc_cnt >= base_acc + 2, 1);
    @(posedge clk); #1;
    rst        = 1'b1;
    flush_fifo = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    flush_fifo = 1'b0;
    exp_q.delete();
    push_idx   = 0;
    @(negedge clk);
    check("t5_m_valid", m_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_fifo_pop", fifo_pop, 0);
    @(posedge clk); #1;

    // 6: FIFO reports empty mid-burst, then the burst resumes
    base_acc = acc_cnt;
    for (int i = 0; i < 4; i++) push_word(32'hD0 + 32'(i), 1'b0);
    n = 0;
    while (acc_cnt < base_acc + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    force_empty = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_pop", fifo_pop, 0);
      check("t6_busy_in_burst", busy, 1);
    end
    @(posedge clk); #1;
    force_empty = 1'b0;
    wait_drain("t6");
    check("t6_beats", acc_cnt - base_acc, 4);

    // random traffic: whole bursts pushed with random gaps, random ready
    ready_mode = 2;
    for (int g = 0; g < 40; g++) begin
      repeat ($urandom_range(0, 6)) begin
        @(posedge clk); #1;
      end
      if (fill <= DEPTH - 2 * BURST_LEN) begin
        for (int i = 0; i < BURST_LEN; i++) push_word($urandom, 1'b0);
      end
    end
    wait_drain("rand");
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
